// File: rtl/bsdiv_pkg.sv
// ---------------------------------------------------------------------------
// bsdiv_pkg
// Shared definitions for the byte-serial divider (bytestream_div).
//   bsdiv_state_e     : control FSM states (LOAD, DIV, FIX, SEND)
//   bsdiv_beats       : beats per operand, N = WIDTH/BUS_W
//   bsdiv_beat_cnt_w  : width of the 0..2N-1 beat counters
//   bsdiv_iter_cnt_w  : width of the iteration counter in bsdiv_core
// ---------------------------------------------------------------------------
package bsdiv_pkg;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_DIV  = 2'd1,
      ST_FIX  = 2'd2,
      ST_SEND = 2'd3
   } bsdiv_state_e;

   function automatic int bsdiv_beats(input int width, input int bus_w);
      return width / bus_w;
   endfunction

   function automatic int bsdiv_beat_cnt_w(input int width, input int bus_w);
      return $clog2(2 * (width / bus_w));
   endfunction

   function automatic int bsdiv_iter_cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/bytestream_div_if.sv
// ---------------------------------------------------------------------------
// bytestream_div_if
// Stream bundle between the host side (master) and the divider (slave).
//   in_valid/in_ready/in_data/in_sign : operand beats into the divider
//   out_valid/out_ready/out_data      : result beats out of the divider
//   out_last/out_sign/out_dbz         : result side-band, valid with out_valid
//   busy                              : divider is in DIV, FIX or SEND
//
// Handshake: a beat transfers on a rising edge where valid && ready. The
// source holds data stable while valid is high and ready is low; valid never
// depends on ready. The divider's ready/valid are pure functions of its state.
// ---------------------------------------------------------------------------
interface bytestream_div_if #(parameter int BUS_W = 8) ();

   logic             in_valid;
   logic             in_ready;
   logic [BUS_W-1:0] in_data;
   logic             in_sign;
   logic             out_valid;
   logic             out_ready;
   logic [BUS_W-1:0] out_data;
   logic             out_last;
   logic             out_sign;
   logic             out_dbz;
   logic             busy;

   modport master (
      output in_valid, in_data, in_sign, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_sign, out_dbz, busy
   );

   modport slave (
      input  in_valid, in_data, in_sign, out_ready,
      output in_ready, out_valid, out_data, out_last, out_sign, out_dbz, busy
   );

endinterface

// File: rtl/bsdiv_core.sv
// ---------------------------------------------------------------------------
// bsdiv_core
// Iterative radix-2 non-restoring magnitude divider, one quotient bit/cycle.
//   clk, rst     : clock, synchronous active-high reset
//   start_i      : load operands and begin WIDTH iterations
//   dividend_i   : dividend magnitude
//   divisor_i    : divisor magnitude
//   done_o       : high during the cycle of the final iteration
//   quot_o       : quotient (valid the cycle after done_o)
//   rem_o        : raw partial remainder, low WIDTH bits
//   rem_neg_o    : raw partial remainder is negative (needs +divisor fix)
// A zero divisor is not special-cased: every step subtracts 0, so the
// quotient comes out all ones and the remainder equals the dividend.
// ---------------------------------------------------------------------------
module bsdiv_core
   import bsdiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             done_o,
   output logic [WIDTH-1:0] quot_o,
   output logic [WIDTH-1:0] rem_o,
   output logic             rem_neg_o
);

   localparam int IW = bsdiv_iter_cnt_w(WIDTH);

   // Partial remainder stays in [-M, M); the shifted value reaches +-2M,
   // hence two guard bits above WIDTH.
   logic [WIDTH+1:0] a_q, a_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [IW-1:0]    cnt_q, cnt_d;
   logic             run_q, run_d;

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] m_ext;
   logic [WIDTH+1:0] a_step;

   always_comb begin
      shifted = {a_q[WIDTH:0], q_q[WIDTH-1]};
      m_ext   = {2'b00, m_q};
      a_step  = a_q[WIDTH+1] ? (shifted + m_ext) : (shifted - m_ext);
   end

   assign done_o    = run_q && (cnt_q == IW'(WIDTH - 1));
   assign quot_o    = q_q;
   assign rem_o     = a_q[WIDTH-1:0];
   assign rem_neg_o = a_q[WIDTH+1];

   always_comb begin
      a_d   = a_q;
      q_d   = q_q;
      m_d   = m_q;
      cnt_d = cnt_q;
      run_d = run_q;
      if (start_i) begin
         a_d   = '0;
         q_d   = dividend_i;
         m_d   = divisor_i;
         cnt_d = '0;
         run_d = 1'b1;
      end else if (run_q) begin
         a_d   = a_step;
         q_d   = {q_q[WIDTH-2:0], ~a_step[WIDTH+1]};
         cnt_d = cnt_q + 1'b1;
         if (done_o) begin
            run_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         q_q   <= '0;
         m_q   <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         a_q   <= a_d;
         q_q   <= q_d;
         m_q   <= m_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

endmodule

// File: rtl/bytestream_div.sv
// ---------------------------------------------------------------------------
// bytestream_div
// Byte-serial WIDTH-bit divider: collects dividend then divisor (MS beat
// first), divides magnitudes in bsdiv_core, applies sign-magnitude signs and
// divide-by-zero handling, then streams remainder then quotient (LS beat
// first).
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : bytestream_div_if stream/side-band signals
//   dbg_state_o   : current FSM state, for observation only
// Optional build macro BSDIV_FAST_ZERO_EN: when |dividend| < |divisor| (and
// divisor nonzero) skip DIV and go straight to FIX with quotient 0.
// ---------------------------------------------------------------------------
module bytestream_div
   import bsdiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int BUS_W = 8
) (
   input  logic         clk,
   input  logic         rst,
   bytestream_div_if.slave bus,
   output bsdiv_state_e dbg_state_o
);

   localparam int N  = bsdiv_beats(WIDTH, BUS_W);
   localparam int CW = bsdiv_beat_cnt_w(WIDTH, BUS_W);
   localparam logic [CW-1:0] LAST_BEAT = CW'(2 * N - 1);

   bsdiv_state_e state_q, state_d;

   logic [CW-1:0]            in_cnt_q, in_cnt_d;
   logic [CW-1:0]            out_cnt_q, out_cnt_d;
   // Holds all accepted beats except the one arriving with the last handshake.
   logic [2*WIDTH-BUS_W-1:0] sr_q, sr_d;
   logic                     sgn_q, sgn_d;
   logic                     zs_q, zs_d;
   logic                     ds_q, ds_d;
   logic [WIDTH-1:0]         zmag_q, zmag_d;
   logic [WIDTH-1:0]         dmag_q, dmag_d;
   logic                     fast_q, fast_d;
   logic [2*WIDTH-1:0]       res_q, res_d;
   logic                     out_sign_q, out_sign_d;
   logic                     out_dbz_q, out_dbz_d;

   logic                     in_hs, out_hs, last_in, go_fast;
   logic [2*WIDTH-1:0]       op_full;
   logic [WIDTH-1:0]         z_raw, d_raw, z_mag, d_mag;
   logic                     cur_sgn, z_neg, d_neg;

   logic                     core_start, core_done, core_rem_neg;
   logic [WIDTH-1:0]         core_quot, core_rem;

   logic [WIDTH-1:0]         q_mag, r_mag, q_res, r_res;
   logic                     dbz;

   assign in_hs   = bus.in_valid && (state_q == ST_LOAD);
   assign out_hs  = bus.out_ready && (state_q == ST_SEND);
   assign last_in = in_hs && (in_cnt_q == LAST_BEAT);

   // Operand decode on the final beat; in_sign is taken from beat 0 only.
   always_comb begin
      op_full = {sr_q, bus.in_data};
      z_raw   = op_full[2*WIDTH-1:WIDTH];
      d_raw   = op_full[WIDTH-1:0];
      cur_sgn = (in_cnt_q == '0) ? bus.in_sign : sgn_q;
      if (cur_sgn) begin
         z_mag = {1'b0, z_raw[WIDTH-2:0]};
         d_mag = {1'b0, d_raw[WIDTH-2:0]};
         z_neg = z_raw[WIDTH-1] & (|z_raw[WIDTH-2:0]);
         d_neg = d_raw[WIDTH-1] & (|d_raw[WIDTH-2:0]);
      end else begin
         z_mag = z_raw;
         d_mag = d_raw;
         z_neg = 1'b0;
         d_neg = 1'b0;
      end
   end

`ifdef BSDIV_FAST_ZERO_EN
   assign go_fast = (z_mag < d_mag) && (d_mag != '0);
`else
   assign go_fast = 1'b0;
`endif

   assign core_start = last_in && !go_fast;

   bsdiv_core #(.WIDTH(WIDTH)) u_core (
      .clk        (clk),
      .rst        (rst),
      .start_i    (core_start),
      .dividend_i (z_mag),
      .divisor_i  (d_mag),
      .done_o     (core_done),
      .quot_o     (core_quot),
      .rem_o      (core_rem),
      .rem_neg_o  (core_rem_neg)
   );

   // FIX: remainder correction, sign application, divide-by-zero override.
   // The corrected remainder is in [0, M), so modulo-2^WIDTH addition on the
   // low bits is exact.
   always_comb begin
      dbz   = (dmag_q == '0);
      q_mag = fast_q ? '0 : core_quot;
      r_mag = fast_q ? zmag_q : (core_rem_neg ? (core_rem + dmag_q) : core_rem);
      if (sgn_q) begin
         q_res = {(zs_q ^ ds_q) & (|q_mag), q_mag[WIDTH-2:0]};
         r_res = {zs_q & (|r_mag), r_mag[WIDTH-2:0]};
      end else begin
         q_res = q_mag;
         r_res = r_mag;
      end
      if (dbz) begin
         q_res = '1;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d    = state_q;
      in_cnt_d   = in_cnt_q;
      out_cnt_d  = out_cnt_q;
      sr_d       = sr_q;
      sgn_d      = sgn_q;
      zs_d       = zs_q;
      ds_d       = ds_q;
      zmag_d     = zmag_q;
      dmag_d     = dmag_q;
      fast_d     = fast_q;
      res_d      = res_q;
      out_sign_d = out_sign_q;
      out_dbz_d  = out_dbz_q;
      unique case (state_q)
         ST_LOAD: begin
            if (in_hs) begin
               sr_d = {sr_q[2*WIDTH-2*BUS_W-1:0], bus.in_data};
               if (in_cnt_q == '0) begin
                  sgn_d = bus.in_sign;
               end
               if (last_in) begin
                  in_cnt_d = '0;
                  zmag_d   = z_mag;
                  dmag_d   = d_mag;
                  zs_d     = z_neg;
                  ds_d     = d_neg;
                  fast_d   = go_fast;
                  state_d  = go_fast ? ST_FIX : ST_DIV;
               end else begin
                  in_cnt_d = in_cnt_q + 1'b1;
               end
            end
         end
         ST_DIV: begin
            if (core_done) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            res_d      = {q_res, r_res};
            out_sign_d = sgn_q;
            out_dbz_d  = dbz;
            out_cnt_d  = '0;
            state_d    = ST_SEND;
         end
         ST_SEND: begin
            if (out_hs) begin
               res_d = {{BUS_W{1'b0}}, res_q[2*WIDTH-1:BUS_W]};
               if (out_cnt_q == LAST_BEAT) begin
                  out_cnt_d = '0;
                  state_d   = ST_LOAD;
               end else begin
                  out_cnt_d = out_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_LOAD;
         in_cnt_q   <= '0;
         out_cnt_q  <= '0;
         sr_q       <= '0;
         sgn_q      <= 1'b0;
         zs_q       <= 1'b0;
         ds_q       <= 1'b0;
         zmag_q     <= '0;
         dmag_q     <= '0;
         fast_q     <= 1'b0;
         res_q      <= '0;
         out_sign_q <= 1'b0;
         out_dbz_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_cnt_q   <= in_cnt_d;
         out_cnt_q  <= out_cnt_d;
         sr_q       <= sr_d;
         sgn_q      <= sgn_d;
         zs_q       <= zs_d;
         ds_q       <= ds_d;
         zmag_q     <= zmag_d;
         dmag_q     <= dmag_d;
         fast_q     <= fast_d;
         res_q      <= res_d;
         out_sign_q <= out_sign_d;
         out_dbz_q  <= out_dbz_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_LOAD);
   assign bus.out_valid = (state_q == ST_SEND);
   assign bus.out_data  = res_q[BUS_W-1:0];
   assign bus.out_last  = (state_q == ST_SEND) && (out_cnt_q == LAST_BEAT);
   assign bus.out_sign  = out_sign_q;
   assign bus.out_dbz   = out_dbz_q;
   assign bus.busy      = (state_q != ST_LOAD);
   assign dbg_state_o   = state_q;

endmodule
